// File: rtl/cache_pkg.sv
// Shared types and field-width helpers for the set-associative read cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_WAIT,
    FLUSH
  } state_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_LINE_BYTES = 4;
  localparam int DEF_SETS       = 16;
  localparam int DEF_WAYS       = 2;

  function automatic int off_w(input int lb);
    return $clog2(lb);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int aw, input int lb,
                               input int sets);
    return aw - $clog2(lb) - $clog2(sets);
  endfunction

  // A way pointer is at least one bit, even when direct-mapped.
  function automatic int ptr_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_way_select.sv
// Victim choice: lowest invalid way, else the set's round-robin pointer.
module cache_way_select
  import cache_pkg::*;
#(
  parameter  int WAYS = DEF_WAYS,
  localparam int PW   = ptr_w(WAYS)
) (
  input  logic [WAYS-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   victim
);

  always_comb begin
    victim = ptr;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = PW'(w);
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative byte-read cache with single-line refill and flush.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int SETS       = DEF_SETS,
  parameter int WAYS       = DEF_WAYS
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  output logic                    req_ready_o,
  output logic                    rsp_valid_o,
  output logic [7:0]              rsp_data_o,
  output logic                    rsp_hit_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_W-1:0]       mem_req_addr_o,
  input  logic                    mem_rsp_valid_i,
  input  logic [LINE_BYTES*8-1:0] mem_rsp_data_i
);

  localparam int OW = off_w(LINE_BYTES);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(ADDR_W, LINE_BYTES, SETS);
  localparam int PW = ptr_w(WAYS);
  localparam int LW = LINE_BYTES * 8;

  state_e            state;
  logic [ADDR_W-1:0] addr_q;

  logic [LW-1:0]   data_q  [SETS][WAYS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [PW-1:0]   ptr_q   [SETS];

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit;
  logic [PW-1:0] hit_way;
  logic [PW-1:0] victim;
  logic [PW-1:0] ptr_nxt;
  logic          fill;

  assign off  = addr_q[OW-1:0];
  assign idx  = addr_q[OW+:IW];
  assign tag  = addr_q[ADDR_W-1-:TW];
  assign fill = (state == REFILL_WAIT) && mem_rsp_valid_i;

  assign ptr_nxt = (ptr_q[idx] == PW'(WAYS - 1)) ? '0
                 : ptr_q[idx] + 1'b1;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = PW'(w);
      end
    end
  end

  cache_way_select #(.WAYS(WAYS)) u_sel (
    .valid  (valid_q[idx]),
    .ptr    (ptr_q[idx]),
    .victim (victim)
  );

  assign req_ready_o = (state == IDLE);

  // Hit and refill data go out combinationally in their own cycle.
  always_comb begin
    rsp_valid_o = 1'b0;
    rsp_hit_o   = 1'b0;
    rsp_data_o  = '0;
    if (state == LOOKUP && hit) begin
      rsp_valid_o = 1'b1;
      rsp_hit_o   = 1'b1;
      rsp_data_o  = 8'(data_q[idx][hit_way] >> {off, 3'b000});
    end else if (fill) begin
      rsp_valid_o = 1'b1;
      rsp_data_o  = 8'(mem_rsp_data_i >> {off, 3'b000});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      addr_q          <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (flush_i) begin
            state <= FLUSH;
          end else if (req_valid_i) begin
            addr_q <= req_addr_i;
            state  <= LOOKUP;
          end
        end
        FLUSH: begin
          for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          state <= IDLE;
        end
        LOOKUP: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
            state           <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= REFILL_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (mem_rsp_valid_i) begin
            valid_q[idx][victim] <= 1'b1;
            if (&valid_q[idx]) ptr_q[idx] <= ptr_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[idx][victim] <= mem_rsp_data_i;
      tag_q[idx][victim]  <= tag;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache at default parameters.
module tb_assoc_cache;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic        req_valid = 0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_hit;
  logic        mreq_valid;
  logic        mreq_ready = 0;
  logic [31:0] mreq_addr;
  logic        mrsp_valid = 0;
  logic [31:0] mrsp_data = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assoc_cache dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .req_valid_i     (req_valid),
    .req_addr_i      (req_addr),
    .req_ready_o     (req_ready),
    .rsp_valid_o     (rsp_valid),
    .rsp_data_o      (rsp_data),
    .rsp_hit_o       (rsp_hit),
    .mem_req_valid_o (mreq_valid),
    .mem_req_ready_i (mreq_ready),
    .mem_req_addr_o  (mreq_addr),
    .mem_rsp_valid_i (mrsp_valid),
    .mem_rsp_data_i  (mrsp_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] line;
    bit          hit;
    logic [7:0]  data;
    int          stall;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] line,
                         input bit ehit, input logic [7:0] ed,
                         input int stall, input string nm);
    logic [31:0] ma;
    bit seen;
    ma = {a[31:2], 2'b00};
    @(negedge clk);
    req_valid = 1;
    req_addr  = a;
    #1 chk({nm, " ready"}, 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 0;
    #1;
    if (ehit) begin
      chk({nm, " hit valid"}, 32'(rsp_valid), 1);
      chk({nm, " hit flag"}, 32'(rsp_hit), 1);
      chk({nm, " hit data"}, 32'(rsp_data), 32'(ed));
      return;
    end
    chk({nm, " miss novalid"}, 32'(rsp_valid), 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1 seen = mreq_valid;
    end
    if (!seen) begin
      chk({nm, " mem req timeout"}, 0, 1);
      return;
    end
    chk({nm, " mem addr"}, mreq_addr, ma);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      chk({nm, " stall valid"}, 32'(mreq_valid), 1);
      chk({nm, " stall addr"}, mreq_addr, ma);
      chk({nm, " stall ready"}, 32'(req_ready), 0);
    end
    mreq_ready = 1;
    @(negedge clk);
    mreq_ready = 0;
    mrsp_valid = 1;
    mrsp_data  = line;
    #1;
    chk({nm, " fill valid"}, 32'(rsp_valid), 1);
    chk({nm, " fill hit"}, 32'(rsp_hit), 0);
    chk({nm, " fill data"}, 32'(rsp_data), 32'(ed));
    @(negedge clk);
    mrsp_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'h000, 32'h44332211, 0, 8'h11, 0};
    vecs[1]  = '{32'h001, 32'h0,        1, 8'h22, 0};
    vecs[2]  = '{32'h040, 32'h88776655, 0, 8'h55, 3};
    vecs[3]  = '{32'h043, 32'h0,        1, 8'h88, 0};
    vecs[4]  = '{32'h082, 32'hCCBBAA99, 0, 8'hBB, 0};
    vecs[5]  = '{32'h040, 32'h0,        1, 8'h55, 0};
    vecs[6]  = '{32'h000, 32'h44332211, 0, 8'h11, 0};
    vecs[7]  = '{32'h081, 32'h0,        1, 8'hAA, 0};
    vecs[8]  = '{32'h006, 32'h0D0C0B0A, 0, 8'h0C, 0};
    vecs[9]  = '{32'h007, 32'h0,        1, 8'h0D, 0};
    vecs[10] = '{32'hFFFFFFC3, 32'h9F8F7F6F, 0, 8'h9F, 1};
    vecs[11] = '{32'h002, 32'h0,        1, 8'h33, 0};
    vecs[12] = '{32'h080, 32'hCCBBAA99, 0, 8'h99, 0};

    #12;
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_hit", 32'(rsp_hit), 0);
    chk("reset rsp_data", 32'(rsp_data), 0);
    chk("reset mreq_valid", 32'(mreq_valid), 0);
    chk("reset mreq_addr", mreq_addr, 0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("reset ready", 32'(req_ready), 1);

    for (int i = 0; i < 13; i++) begin
      do_read(vecs[i].addr, vecs[i].line, vecs[i].hit,
              vecs[i].data, vecs[i].stall, $sformatf("vec%0d", i));
    end

    // flush beats a simultaneous request and drops the line
    do_read(32'h000, 32'h44332211, 0, 8'h11, 0, "prefl");
    @(negedge clk);
    flush     = 1;
    req_valid = 1;
    req_addr  = 32'h001;
    @(negedge clk);
    flush     = 0;
    req_valid = 0;
    #1;
    chk("flush ready low", 32'(req_ready), 0);
    chk("flush no rsp", 32'(rsp_valid), 0);
    chk("flush no mreq", 32'(mreq_valid), 0);
    @(negedge clk);
    #1 chk("flush back idle", 32'(req_ready), 1);
    chk("flush no rsp2", 32'(rsp_valid), 0);
    do_read(32'h001, 32'h44332211, 0, 8'h22, 0, "postfl");

    // reset in REFILL_WAIT abandons the refill
    @(negedge clk);
    req_valid = 1;
    req_addr  = 32'h100;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    #1 chk("rst mreq", 32'(mreq_valid), 1);
    mreq_ready = 1;
    @(negedge clk);
    mreq_ready = 0;
    rst_n = 0;
    #1;
    chk("rst mid rsp", 32'(rsp_valid), 0);
    chk("rst mid mreq", 32'(mreq_valid), 0);
    chk("rst mid ready", 32'(req_ready), 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mrsp_valid = 1;
    mrsp_data  = 32'hDEADBEEF;
    #1;
    chk("late rsp ignored", 32'(rsp_valid), 0);
    chk("late rsp ready", 32'(req_ready), 1);
    @(negedge clk);
    mrsp_valid = 0;
    #1 chk("late rsp ready2", 32'(req_ready), 1);
    do_read(32'h100, 32'h13121110, 0, 8'h10, 0, "rerd");
    do_read(32'h000, 32'h44332211, 0, 8'h11, 0, "rstclr");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the request address width in bits.
REQ-002 Parameter LINE_BYTES, default 4, SHALL set the bytes per line (power of two, >=2).
REQ-003 Parameter SETS, default 16, SHALL set the number of sets (power of two, >=2).
REQ-004 Parameter WAYS, default 2, SHALL set the associativity (1..8).
REQ-005 clk_i  in  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-006 rst_ni  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 flush_i  in  1  SHALL request invalidation of all lines.
REQ-008 req_valid_i  in  1  SHALL qualify a byte read request.
REQ-009 req_addr_i  in  ADDR_W  SHALL carry the byte address.
REQ-010 req_ready_o  out  1  SHALL indicate that a request or flush can be accepted.
REQ-011 rsp_valid_o  out  1  SHALL pulse for one cycle with the read result.
REQ-012 rsp_data_o  out  8  SHALL carry the read byte.
REQ-013 rsp_hit_o  out  1  SHALL be 1 when the response was a hit.
REQ-014 mem_req_valid_o / mem_req_ready_i  out/in  1/1  SHALL form the refill-request handshake.
REQ-015 mem_req_addr_o  out  ADDR_W  SHALL carry the line-aligned refill address (offset bits 0).
REQ-016 mem_rsp_valid_i / mem_rsp_data_i  in/in  1/LINE_BYTES*8  SHALL return a full line; byte 0 SHALL be in bits [7:0].

Function
REQ-017 Address fields SHALL be: offset = low log2(LINE_BYTES) bits, index = next log2(SETS) bits, tag = the remaining upper bits.
REQ-018 FSM states SHALL be IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, FLUSH.
REQ-019 req_ready_o SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid_i && req_ready_o, and its address SHALL be registered.
REQ-020 flush_i in IDLE SHALL win over a simultaneous req_valid_i: enter FLUSH, clear every valid bit in that cycle, return to IDLE, and raise no rsp_valid_o.
REQ-021 LOOKUP SHALL compare the tag against all ways of the indexed set; on a hit, rsp_valid_o=1, rsp_hit_o=1, and the selected byte SHALL be output in that cycle (accept edge +1), then return to IDLE.
REQ-022 A miss SHALL enter REFILL_REQ with mem_req_valid_o=1; mem_req_addr_o SHALL stay stable until mem_req_ready_i=1, then enter REFILL_WAIT.
REQ-023 In REFILL_WAIT, mem_rsp_valid_i SHALL write the line and tag into the victim way, set valid, update the set's victim pointer, and drive rsp_valid_o=1, rsp_hit_o=0 with the requested byte from mem_rsp_data_i in the same cycle; then return to IDLE.
REQ-024 Victim SHALL be the lowest-numbered invalid way; otherwise the per-set round-robin pointer, which SHALL advance (mod WAYS) only on a refill into a fully valid set.
REQ-025 mem_rsp_valid_i outside REFILL_WAIT and flush_i outside IDLE SHALL be ignored.
REQ-026 With WAYS=1 the block SHALL behave as direct-mapped.

Reset
REQ-027 rst_ni low SHALL immediately force IDLE, all valid bits 0, all victim pointers 0, req_ready_o=1 after release, and rsp_valid_o, rsp_hit_o, rsp_data_o, mem_req_valid_o, mem_req_addr_o all 0; data/tag storage need not be reset.
REQ-028 Reset asserted mid-refill SHALL abandon the refill; a late mem_rsp_valid_i SHALL then be ignored.

Structure
REQ-029 Package cache_pkg SHALL hold the FSM state enum, default parameter constants, and the field-width functions (offset, index, tag widths).
REQ-030 Victim selection SHALL be a sub-module named cache_way_select (inputs: valid vector and pointer; output: victim way).

Verification (defaults; set 0 = addresses 0x000, 0x040, 0x080)
REQ-031 Read 0x000 after reset -> mem_req_addr_o=0x000; refill data 0x44332211 -> rsp_data_o=0x11, rsp_hit_o=0; then read 0x001 -> rsp_data_o=0x22, rsp_hit_o=1, one cycle after acceptance.
REQ-032 Fill 0x000 then 0x040; read 0x080 (miss, evicts way 0) -> the next read of 0x000 misses and 0x040 hits.
REQ-033 Fill 0x000; flush_i=1 together with req_valid_i for 0x001 -> flush takes priority, no response; the following read of 0x001 misses.
REQ-034 Hold mem_req_ready_i=0 for 3 cycles -> mem_req_valid_o=1 and mem_req_addr_o constant; req_ready_o=0 throughout.
REQ-035 rst_ni low in REFILL_WAIT, then mem_rsp_valid_i=1 after release -> no rsp_valid_o, req_ready_o=1, and a re-read of the same address misses.
